// File: rtl/polar_mem_pkg.sv
// Shared LLR memory geometry for the SC polar decoder (BRAM, PEs, arbiter).
// Also defines the round-robin side encoding used by the write-port arbiter.
package polar_mem_pkg;

    localparam int unsigned N_DEFAULT = 5;
    localparam int unsigned P_DEFAULT = 1;
    localparam int unsigned Q_DEFAULT = 6;

    typedef enum logic {
        SIDE_LD = 1'b0,
        SIDE_WB = 1'b1
    } rr_side_e;

    function automatic int unsigned data_width(input int unsigned p, input int unsigned q);
        return (32'd1 << p) * q;
    endfunction

    function automatic int unsigned mem_depth(input int unsigned n, input int unsigned p);
        return (32'd1 << (n - p)) - 32'd2 + p;
    endfunction

    function automatic int unsigned addr_width(input int unsigned n, input int unsigned p);
        return $clog2(mem_depth(n, p));
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; the pointer moves only on a contended grant.
module rr_arb2
    import polar_mem_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_c
);

    rr_side_e ptr_q;
    rr_side_e ptr_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= SIDE_LD;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (!rst && (&req_i)) begin
            ptr_d = (ptr_q == SIDE_LD) ? SIDE_WB : SIDE_LD;
        end
    end

    always_comb begin
        gnt_c = 2'b00;
        if (!rst) begin
            if (&req_i) begin
                case (ptr_q)
                    SIDE_LD: gnt_c = 2'b01;
                    SIDE_WB: gnt_c = 2'b10;
                    default: gnt_c = 2'b00;
                endcase
            end else begin
                gnt_c = req_i;
            end
        end
    end

endmodule

// File: rtl/llr_bram_arbiter.sv
// Controller in front of the 1W/2R LLR block RAM: write-port arbitration,
// fixed-latency dual reads, read-after-write collision stall and range checking.
module llr_bram_arbiter
    import polar_mem_pkg::*;
#(
    parameter  int unsigned n          = N_DEFAULT,
    parameter  int unsigned p          = P_DEFAULT,
    parameter  int unsigned Q          = Q_DEFAULT,
    localparam int unsigned DATA_WIDTH = data_width(p, Q),
    localparam int unsigned DEPTH      = mem_depth(n, p),
    localparam int unsigned ADDR_WIDTH = addr_width(n, p)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ld_req,
    input  logic [ADDR_WIDTH-1:0] ld_addr,
    input  logic [DATA_WIDTH-1:0] ld_data,
    output logic                  ld_gnt,
    input  logic                  wb_req,
    input  logic [ADDR_WIDTH-1:0] wb_addr,
    input  logic [DATA_WIDTH-1:0] wb_data,
    output logic                  wb_gnt,
    input  logic                  rd_req,
    input  logic [ADDR_WIDTH-1:0] rd_addra,
    input  logic [ADDR_WIDTH-1:0] rd_addrb,
    output logic                  rd_ready,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_dataa,
    output logic [DATA_WIDTH-1:0] rd_datab,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_wr_addr,
    output logic [DATA_WIDTH-1:0] mem_din,
    output logic                  mem_rea,
    output logic                  mem_reb,
    output logic [ADDR_WIDTH-1:0] mem_rd_addra,
    output logic [ADDR_WIDTH-1:0] mem_rd_addrb,
    input  logic [DATA_WIDTH-1:0] mem_douta,
    input  logic [DATA_WIDTH-1:0] mem_doutb,
    output logic                  err
);

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        return 32'(a) < DEPTH;
    endfunction

    logic [1:0]            gnt_c;
    logic                  wr_gnt_c;
    logic [ADDR_WIDTH-1:0] wr_addr_c;
    logic [DATA_WIDTH-1:0] wr_data_c;
    logic                  collide_c;
    logic                  rd_acc_c;

    logic                  mem_we_q,       mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_wr_addr_q,  mem_wr_addr_d;
    logic [DATA_WIDTH-1:0] mem_din_q,      mem_din_d;
    logic                  mem_rea_q,      mem_rea_d;
    logic                  mem_reb_q,      mem_reb_d;
    logic [ADDR_WIDTH-1:0] mem_rd_addra_q, mem_rd_addra_d;
    logic [ADDR_WIDTH-1:0] mem_rd_addrb_q, mem_rd_addrb_d;
    logic [1:0]            rd_pipe_q,      rd_pipe_d;
    logic                  err_q,          err_d;

    rr_arb2 u_arb (
        .clk   (clk),
        .rst   (rst),
        .req_i ({wb_req, ld_req}),
        .gnt_c (gnt_c)
    );

    assign ld_gnt    = gnt_c[0];
    assign wb_gnt    = gnt_c[1];
    assign wr_gnt_c  = |gnt_c;
    assign wr_addr_c = gnt_c[1] ? wb_addr : ld_addr;
    assign wr_data_c = gnt_c[1] ? wb_data : ld_data;

    // A read sharing an edge with a same-address write would return stale data.
    assign collide_c = wr_gnt_c && ((wr_addr_c == rd_addra) || (wr_addr_c == rd_addrb));
    assign rd_ready  = !rst && !collide_c;
    assign rd_acc_c  = rd_req && rd_ready;

    always_comb begin
        mem_we_d       = wr_gnt_c && in_range(wr_addr_c);
        mem_wr_addr_d  = wr_gnt_c ? wr_addr_c : mem_wr_addr_q;
        mem_din_d      = wr_gnt_c ? wr_data_c : mem_din_q;
        mem_rea_d      = rd_acc_c && in_range(rd_addra);
        mem_reb_d      = rd_acc_c && in_range(rd_addrb);
        mem_rd_addra_d = rd_acc_c ? rd_addra : mem_rd_addra_q;
        mem_rd_addrb_d = rd_acc_c ? rd_addrb : mem_rd_addrb_q;
        rd_pipe_d      = {rd_pipe_q[0], rd_acc_c};
        err_d          = err_q
                       | (wr_gnt_c && !in_range(wr_addr_c))
                       | (rd_acc_c && (!in_range(rd_addra) || !in_range(rd_addrb)));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_we_q       <= 1'b0;
            mem_wr_addr_q  <= '0;
            mem_din_q      <= '0;
            mem_rea_q      <= 1'b0;
            mem_reb_q      <= 1'b0;
            mem_rd_addra_q <= '0;
            mem_rd_addrb_q <= '0;
            rd_pipe_q      <= 2'b00;
            err_q          <= 1'b0;
        end else begin
            mem_we_q       <= mem_we_d;
            mem_wr_addr_q  <= mem_wr_addr_d;
            mem_din_q      <= mem_din_d;
            mem_rea_q      <= mem_rea_d;
            mem_reb_q      <= mem_reb_d;
            mem_rd_addra_q <= mem_rd_addra_d;
            mem_rd_addrb_q <= mem_rd_addrb_d;
            rd_pipe_q      <= rd_pipe_d;
            err_q          <= err_d;
        end
    end

    assign mem_we       = mem_we_q;
    assign mem_wr_addr  = mem_wr_addr_q;
    assign mem_din      = mem_din_q;
    assign mem_rea      = mem_rea_q;
    assign mem_reb      = mem_reb_q;
    assign mem_rd_addra = mem_rd_addra_q;
    assign mem_rd_addrb = mem_rd_addrb_q;
    assign err          = err_q;
    assign rd_valid     = rd_pipe_q[1];

    // Gate with valid so a read dropped by reset cannot leak BRAM output.
    assign rd_dataa = rd_valid ? mem_douta : '0;
    assign rd_datab = rd_valid ? mem_doutb : '0;

endmodule

// File: tb/tb_llr_bram_arbiter.sv
// Directed bench for llr_bram_arbiter with a behavioural 1W/2R BRAM attached.
module tb_llr_bram_arbiter;

    localparam int unsigned DW = 12;
    localparam int unsigned AW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          ld_req, wb_req, rd_req;
    logic [AW-1:0] ld_addr, wb_addr, rd_addra, rd_addrb;
    logic [DW-1:0] ld_data, wb_data;
    logic          ld_gnt, wb_gnt, rd_ready, rd_valid, err;
    logic [DW-1:0] rd_dataa, rd_datab;
    logic          mem_we, mem_rea, mem_reb;
    logic [AW-1:0] mem_wr_addr, mem_rd_addra, mem_rd_addrb;
    logic [DW-1:0] mem_din;
    logic [DW-1:0] mem_douta = '0;
    logic [DW-1:0] mem_doutb = '0;
    logic [DW-1:0] bram [16];

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    llr_bram_arbiter dut (
        .clk(clk), .rst(rst),
        .ld_req(ld_req), .ld_addr(ld_addr), .ld_data(ld_data), .ld_gnt(ld_gnt),
        .wb_req(wb_req), .wb_addr(wb_addr), .wb_data(wb_data), .wb_gnt(wb_gnt),
        .rd_req(rd_req), .rd_addra(rd_addra), .rd_addrb(rd_addrb), .rd_ready(rd_ready),
        .rd_valid(rd_valid), .rd_dataa(rd_dataa), .rd_datab(rd_datab),
        .mem_we(mem_we), .mem_wr_addr(mem_wr_addr), .mem_din(mem_din),
        .mem_rea(mem_rea), .mem_reb(mem_reb),
        .mem_rd_addra(mem_rd_addra), .mem_rd_addrb(mem_rd_addrb),
        .mem_douta(mem_douta), .mem_doutb(mem_doutb), .err(err)
    );

    // Behavioural Multiport_BRAM: registered reads, zero output when not enabled
    always @(posedge clk) begin
        if (mem_we) bram[mem_wr_addr] <= mem_din;
        mem_douta <= mem_rea ? bram[mem_rd_addra] : '0;
        mem_doutb <= mem_reb ? bram[mem_rd_addrb] : '0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        rst = 1'b1;
        ld_req = 1'b0; wb_req = 1'b0; rd_req = 1'b0;
        ld_addr = '0; wb_addr = '0; rd_addra = '0; rd_addrb = '0;
        ld_data = '0; wb_data = '0;

        // Reset state, with requests asserted to confirm they are masked
        @(negedge clk); @(negedge clk);
        ld_req = 1'b1; wb_req = 1'b1; rd_req = 1'b1; ld_addr = 4'd3;
        #1;
        chk("rst_ld_gnt",   32'(ld_gnt),      32'd0);
        chk("rst_wb_gnt",   32'(wb_gnt),      32'd0);
        chk("rst_rd_ready", 32'(rd_ready),    32'd0);
        chk("rst_mem_we",   32'(mem_we),      32'd0);
        chk("rst_mem_rea",  32'(mem_rea),     32'd0);
        chk("rst_mem_reb",  32'(mem_reb),     32'd0);
        chk("rst_rd_valid", 32'(rd_valid),    32'd0);
        chk("rst_rd_dataa", 32'(rd_dataa),    32'd0);
        chk("rst_wr_addr",  32'(mem_wr_addr), 32'd0);
        chk("rst_err",      32'(err),         32'd0);

        // Single LD write
        @(negedge clk);
        rst = 1'b0; wb_req = 1'b0; rd_req = 1'b0;
        ld_req = 1'b1; ld_addr = 4'd3; ld_data = 12'hABC;
        #1;
        chk("ld_gnt_single", 32'(ld_gnt), 32'd1);
        chk("wb_gnt_single", 32'(wb_gnt), 32'd0);
        @(negedge clk);
        ld_req = 1'b0;
        #1;
        chk("ld_mem_we",   32'(mem_we),      32'd1);
        chk("ld_mem_addr", 32'(mem_wr_addr), 32'd3);
        chk("ld_mem_din",  32'(mem_din),     32'hABC);
        @(negedge clk);
        #1;
        chk("ld_mem_we_off", 32'(mem_we), 32'd0);

        // Contention: LD,WB,LD,WB
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            ld_req = 1'b1; ld_addr = 4'd1; ld_data = 12'h111;
            wb_req = 1'b1; wb_addr = 4'd7; wb_data = 12'h777;
            #1;
            chk("cont_ld_gnt", 32'(ld_gnt), 32'((i % 2) == 0));
            chk("cont_wb_gnt", 32'(wb_gnt), 32'((i % 2) == 1));
        end
        @(negedge clk);
        ld_req = 1'b0;
        #1;
        chk("wb_only_gnt",  32'(wb_gnt),      32'd1);
        chk("cont_wr_addr", 32'(mem_wr_addr), 32'd7);
        chk("cont_din",     32'(mem_din),     32'h777);
        @(negedge clk);
        ld_req = 1'b1;
        #1;
        chk("ptr_held_ld", 32'(ld_gnt), 32'd1);
        @(negedge clk);
        wb_req = 1'b0;
        #1;
        chk("ld_only_gnt", 32'(ld_gnt), 32'd1);
        @(negedge clk);
        wb_req = 1'b1;
        #1;
        chk("ptr_wb_gnt", 32'(wb_gnt), 32'd1);
        chk("ptr_wb_ld",  32'(ld_gnt), 32'd0);
        @(negedge clk);
        ld_req = 1'b0; wb_req = 1'b0;

        // Write 0x123 to 5, read (5,7) two cycles later
        @(negedge clk);
        ld_req = 1'b1; ld_addr = 4'd5; ld_data = 12'h123;
        #1;
        chk("rd_wr_gnt", 32'(ld_gnt), 32'd1);
        @(negedge clk);
        ld_req = 1'b0;
        @(negedge clk);
        rd_req = 1'b1; rd_addra = 4'd5; rd_addrb = 4'd7;
        #1;
        chk("rd_ready", 32'(rd_ready), 32'd1);
        @(negedge clk);
        rd_req = 1'b0;
        #1;
        chk("rd_mem_rea",   32'(mem_rea),      32'd1);
        chk("rd_mem_reb",   32'(mem_reb),      32'd1);
        chk("rd_mem_addra", 32'(mem_rd_addra), 32'd5);
        chk("rd_mem_addrb", 32'(mem_rd_addrb), 32'd7);
        chk("rd_valid_t1",  32'(rd_valid),     32'd0);
        @(negedge clk);
        #1;
        chk("rd_valid_t2", 32'(rd_valid), 32'd1);
        chk("rd_dataa",    32'(rd_dataa), 32'h123);
        chk("rd_datab",    32'(rd_datab), 32'h777);
        @(negedge clk);
        #1;
        chk("rd_valid_t3", 32'(rd_valid), 32'd0);
        chk("rd_dataa_t3", 32'(rd_dataa), 32'd0);

        // Collision stall on wb addr 9, then retry alongside a non-colliding LD write
        @(negedge clk);
        wb_req = 1'b1; wb_addr = 4'd9; wb_data = 12'h055;
        rd_req = 1'b1; rd_addra = 4'd3; rd_addrb = 4'd9;
        #1;
        chk("col_wb_gnt",   32'(wb_gnt),   32'd1);
        chk("col_rd_ready", 32'(rd_ready), 32'd0);
        @(negedge clk);
        wb_req = 1'b0;
        ld_req = 1'b1; ld_addr = 4'd4; ld_data = 12'h044;
        #1;
        chk("col_ld_gnt",     32'(ld_gnt),   32'd1);
        chk("col_retry_ready", 32'(rd_ready), 32'd1);
        @(negedge clk);
        ld_req = 1'b0; rd_req = 1'b0;
        #1;
        chk("col_stalled_novalid", 32'(rd_valid), 32'd0);
        chk("col_mem_rea",         32'(mem_rea),  32'd1);
        @(negedge clk);
        #1;
        chk("col_rd_valid", 32'(rd_valid), 32'd1);
        chk("col_rd_dataa", 32'(rd_dataa), 32'hABC);
        chk("col_rd_datab", 32'(rd_datab), 32'h055);

        // Out-of-range write and read
        @(negedge clk);
        ld_req = 1'b1; ld_addr = 4'd15; ld_data = 12'hFFF;
        #1;
        chk("oor_ld_gnt",  32'(ld_gnt), 32'd1);
        chk("oor_err_pre", 32'(err),    32'd0);
        @(negedge clk);
        ld_req = 1'b0;
        rd_req = 1'b1; rd_addra = 4'd15; rd_addrb = 4'd3;
        #1;
        chk("oor_mem_we",   32'(mem_we),   32'd0);
        chk("oor_err",      32'(err),      32'd1);
        chk("oor_rd_ready", 32'(rd_ready), 32'd1);
        @(negedge clk);
        rd_req = 1'b0;
        #1;
        chk("oor_mem_rea", 32'(mem_rea), 32'd0);
        chk("oor_mem_reb", 32'(mem_reb), 32'd1);
        @(negedge clk);
        #1;
        chk("oor_rd_valid", 32'(rd_valid), 32'd1);
        chk("oor_rd_dataa", 32'(rd_dataa), 32'd0);
        chk("oor_rd_datab", 32'(rd_datab), 32'hABC);
        chk("oor_err_held", 32'(err),      32'd1);

        // Reset the cycle after a read is accepted, with a write in flight
        @(negedge clk);
        rd_req = 1'b1; rd_addra = 4'd5; rd_addrb = 4'd7;
        ld_req = 1'b1; ld_addr = 4'd6; ld_data = 12'h066;
        wb_req = 1'b1; wb_addr = 4'd8; wb_data = 12'h088;
        #1;
        chk("mid_ld_gnt",   32'(ld_gnt),   32'd1);
        chk("mid_rd_ready", 32'(rd_ready), 32'd1);
        @(negedge clk);
        rst = 1'b1; rd_req = 1'b0;
        #1;
        chk("mid_rst_ld_gnt",  32'(ld_gnt),      32'd0);
        chk("mid_rst_wb_gnt",  32'(wb_gnt),      32'd0);
        chk("mid_rst_mem_we",  32'(mem_we),      32'd1);
        chk("mid_rst_wr_addr", 32'(mem_wr_addr), 32'd6);
        @(negedge clk);
        rst = 1'b0; ld_addr = 4'd10; ld_data = 12'h0AA;
        #1;
        chk("mid_ptr_ld_gnt", 32'(ld_gnt),   32'd1);
        chk("mid_ptr_wb_gnt", 32'(wb_gnt),   32'd0);
        chk("mid_rd_valid",   32'(rd_valid), 32'd0);
        chk("mid_rd_dataa",   32'(rd_dataa), 32'd0);
        chk("mid_err_clr",    32'(err),      32'd0);
        chk("mid_mem_we",     32'(mem_we),   32'd0);
        @(negedge clk);
        ld_req = 1'b0; wb_req = 1'b0;
        #1;
        chk("mid_rd_valid_late", 32'(rd_valid), 32'd0);
        @(negedge clk);
        rd_req = 1'b1; rd_addra = 4'd6; rd_addrb = 4'd10;
        #1;
        chk("post_rd_ready", 32'(rd_ready), 32'd1);
        @(negedge clk);
        rd_req = 1'b0;
        @(negedge clk);
        #1;
        chk("post_rd_valid", 32'(rd_valid), 32'd1);
        chk("post_committed", 32'(rd_dataa), 32'h066);
        chk("post_rd_datab",  32'(rd_datab), 32'h0AA);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
